// File: rtl/vrf_wb_sequencer.sv
// vrf_wb_sequencer
//   Write-side initiator for the banked vector register file. Accepts one
//   writeback command, gathers all of its result slices into a local buffer,
//   then drives the VRF write port for exactly num_slices back-to-back cycles
//   so the VRF's internal write-slice counter steps once per slice.
//
//   Handshakes: a transfer happens on a rising clk edge where valid && ready
//   are both high. valid must not depend on ready. ready is a pure function
//   of the current state (cmd_ready in IDLE, in_ready in FILL), so either
//   side may hold valid high for as many cycles as it needs.
module vrf_wb_sequencer #(
   parameter int LANES      = 4,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 12,
   parameter int MAX_SLICES = 8,
   parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic [ADDR_WIDTH-1:0]       cmd_vd_addr,
   input  logic [3:0]                  cmd_num_slices,
   input  logic [7:0]                  cmd_vl,
   input  logic [1:0]                  cmd_vsew,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [LANES*DATA_WIDTH-1:0] in_data,
   output logic                        write_en,
   output logic [ADDR_WIDTH-1:0]       vd_addr_o,
   output logic [LANES*DATA_WIDTH-1:0] vd_data,
   output logic [7:0]                  vl_o,
   output logic [1:0]                  vsew_o,
   output logic [3:0]                  max_write_cnt,
   output logic                        busy,
   output logic                        done,
   output logic                        cmd_err,
   output logic [1:0]                  dbg_state
);

   localparam int SLICE_W = LANES * DATA_WIDTH;
   localparam int IW      = (MAX_SLICES > 1) ? $clog2(MAX_SLICES) : 1;
   // Sum width wide enough for addr + num_slices without overflow.
   localparam int SW      = ((ADDR_WIDTH > 4) ? ADDR_WIDTH : 4) + 1;
   localparam logic [SW-1:0] NUM_REGS_W   = SW'(NUM_REGS);
   localparam logic [3:0]    MAX_SLICES_W = 4'(MAX_SLICES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [3:0]             fill_cnt_q;
   logic [3:0]             drain_cnt_q;
   logic [3:0]             num_q;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [7:0]             vl_q;
   logic [1:0]             vsew_q;
   logic                   done_q;
   logic                   err_q;
   logic [SLICE_W-1:0]     buf_q [MAX_SLICES];

   logic                   cmd_hs;
   logic                   in_hs;
   logic                   cmd_bad;
   logic                   last_beat;
   logic                   last_drain;
   logic [SW-1:0]          end_reg;

   assign cmd_hs     = cmd_valid && cmd_ready;
   assign in_hs      = in_valid && in_ready;
   assign end_reg    = {{(SW-ADDR_WIDTH){1'b0}}, cmd_vd_addr} +
                       {{(SW-4){1'b0}}, cmd_num_slices};
   assign cmd_bad    = (cmd_num_slices == 4'd0) ||
                       (cmd_num_slices > MAX_SLICES_W) ||
                       (end_reg > NUM_REGS_W);
   assign last_beat  = (fill_cnt_q == num_q - 4'd1);
   assign last_drain = (drain_cnt_q == num_q - 4'd1);

   // Next-state and handshake/write-port control from the current state.
   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      in_ready  = 1'b0;
      write_en  = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid && !cmd_bad) state_d = FILL;
         end
         FILL: begin
            in_ready = 1'b1;
            if (in_valid && last_beat) state_d = DRAIN;
         end
         DRAIN: begin
            write_en = 1'b1;
            if (last_drain) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, command latches, counters and the one-cycle status pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         fill_cnt_q  <= 4'd0;
         drain_cnt_q <= 4'd0;
         num_q       <= 4'd0;
         addr_q      <= '0;
         vl_q        <= 8'd0;
         vsew_q      <= 2'd0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= cmd_hs && cmd_bad;
         done_q  <= (state_q == DRAIN) && last_drain;
         if (cmd_hs && !cmd_bad) begin
            addr_q      <= cmd_vd_addr;
            vl_q        <= cmd_vl;
            vsew_q      <= cmd_vsew;
            num_q       <= cmd_num_slices;
            fill_cnt_q  <= 4'd0;
            drain_cnt_q <= 4'd0;
         end
         if (in_hs) fill_cnt_q <= fill_cnt_q + 4'd1;
         if (write_en) drain_cnt_q <= drain_cnt_q + 4'd1;
      end
   end

   // Slice buffer; contents are don't-care after reset, so no reset here.
   always_ff @(posedge clk) begin
      if (in_hs) buf_q[fill_cnt_q[IW-1:0]] <= in_data;
   end

   assign vd_data       = write_en ? buf_q[drain_cnt_q[IW-1:0]] : '0;
   assign vd_addr_o     = addr_q;
   assign vl_o          = vl_q;
   assign vsew_o        = vsew_q;
   assign max_write_cnt = num_q;
   assign busy          = (state_q != IDLE);
   assign done          = done_q;
   assign cmd_err       = err_q;
   assign dbg_state     = state_q;

endmodule
